// File: rtl/writeback_arbiter.sv
// writeback_arbiter: per-unit skid FIFOs for ALU/MUL/DIV results, drained round-robin onto one register-file write port.
// Optional macro WB_BYPASS_EN: an empty unit's input competes for the write port in the same cycle it arrives.
module writeback_arbiter #(
    parameter int FIFO_DEPTH     = 8,
    parameter int REG_WIDTH      = 5,
    parameter int LATENCY_MUL_OP = 2,
    parameter int AF_MARGIN      = LATENCY_MUL_OP + 2
) (
    input  logic                  clk,
    input  logic                  rst,
    // each *_wb_inf is {instruction_valid, register_write, rd, exe_result[31:0]}
    input  logic [REG_WIDTH+33:0] alu_wb_inf,
    input  logic [REG_WIDTH+33:0] mul_wb_inf,
    input  logic [REG_WIDTH+33:0] div_wb_inf,
    output logic                  alu_almost_full,
    output logic                  mul_almost_full,
    output logic                  div_almost_full,
    output logic                  rf_write,
    output logic [REG_WIDTH-1:0]  rf_rd,
    output logic [31:0]           rf_data,
    output logic [2:0]            overflow_err
);
    localparam int PW     = $clog2(FIFO_DEPTH) + 1;
    localparam int EW     = REG_WIDTH + 32;
    localparam int AF_INT = (FIFO_DEPTH > AF_MARGIN) ? FIFO_DEPTH - AF_MARGIN : 0;
    localparam logic [PW-1:0] AF_LEVEL = AF_INT[PW-1:0];

    logic [REG_WIDTH+33:0] wb_in [3];
    logic [EW-1:0]         mem [3][FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr [3];
    logic [PW-1:0]         rd_ptr [3];
    logic [PW-1:0]         wr_nxt [3];
    logic [PW-1:0]         rd_nxt [3];
    logic [PW-1:0]         occ_nxt [3];
    logic [EW-1:0]         in_ent [3];
    logic [EW-1:0]         head [3];
    logic [2:0]            in_vld, empty, full, cand, gnt, pop, push, byp, ovf, af_nxt;
    logic [1:0]            last_grant, gnt_idx;
    logic                  gnt_any;
    logic [EW-1:0]         gnt_ent;

    assign wb_in[0] = alu_wb_inf;
    assign wb_in[1] = mul_wb_inf;
    assign wb_in[2] = div_wb_inf;

    function automatic logic [1:0] rr_next(input logic [1:0] src);
        return (src == 2'd2) ? 2'd0 : src + 2'd1;
    endfunction

    always_comb begin
        for (int s = 0; s < 3; s++) begin
            in_vld[s] = wb_in[s][EW+1] && wb_in[s][EW] && (wb_in[s][EW-1:32] != '0);
            in_ent[s] = wb_in[s][EW-1:0];
            empty[s]  = (wr_ptr[s] == rd_ptr[s]);
            full[s]   = (wr_ptr[s][PW-1] != rd_ptr[s][PW-1]) &&
                        (wr_ptr[s][PW-2:0] == rd_ptr[s][PW-2:0]);
            head[s]   = mem[s][rd_ptr[s][PW-2:0]];
`ifdef WB_BYPASS_EN
            cand[s]   = !empty[s] || in_vld[s];
`else
            cand[s]   = !empty[s];
`endif
        end
    end

    // Round-robin search begins at the source after the last grant.
    always_comb begin
        logic [1:0] idx;
        gnt     = '0;
        gnt_any = 1'b0;
        gnt_idx = last_grant;
        idx     = last_grant;
        for (int k = 0; k < 3; k++) begin
            idx = rr_next(idx);
            if (!gnt_any && cand[idx]) begin
                gnt[idx] = 1'b1;
                gnt_any  = 1'b1;
                gnt_idx  = idx;
            end
        end
    end

    always_comb begin
        gnt_ent = head[0];
        for (int s = 0; s < 3; s++) begin
            if (gnt[s]) begin
`ifdef WB_BYPASS_EN
                gnt_ent = empty[s] ? in_ent[s] : head[s];
`else
                gnt_ent = head[s];
`endif
            end
        end
    end

    // A full FIFO still accepts a push when it is popped in the same cycle.
    always_comb begin
        for (int s = 0; s < 3; s++) begin
            pop[s]     = gnt[s] && !empty[s];
            byp[s]     = gnt[s] && empty[s];
            push[s]    = in_vld[s] && !byp[s] && (!full[s] || pop[s]);
            ovf[s]     = in_vld[s] && full[s] && !pop[s];
            wr_nxt[s]  = wr_ptr[s] + {{(PW-1){1'b0}}, push[s]};
            rd_nxt[s]  = rd_ptr[s] + {{(PW-1){1'b0}}, pop[s]};
            occ_nxt[s] = wr_nxt[s] - rd_nxt[s];
            af_nxt[s]  = (occ_nxt[s] >= AF_LEVEL);
        end
    end

    always_ff @(posedge clk) begin
        for (int s = 0; s < 3; s++) begin
            if (push[s]) mem[s][wr_ptr[s][PW-2:0]] <= in_ent[s];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr          <= '{default: '0};
            rd_ptr          <= '{default: '0};
            last_grant      <= 2'd2;
            rf_write        <= 1'b0;
            rf_rd           <= '0;
            rf_data         <= '0;
            alu_almost_full <= 1'b0;
            mul_almost_full <= 1'b0;
            div_almost_full <= 1'b0;
            overflow_err    <= 3'b000;
        end else begin
            for (int s = 0; s < 3; s++) begin
                wr_ptr[s] <= wr_nxt[s];
                rd_ptr[s] <= rd_nxt[s];
            end
            if (gnt_any) begin
                last_grant       <= gnt_idx;
                {rf_rd, rf_data} <= gnt_ent;
            end
            rf_write        <= gnt_any;
            alu_almost_full <= af_nxt[0];
            mul_almost_full <= af_nxt[1];
            div_almost_full <= af_nxt[2];
            overflow_err    <= overflow_err | ovf;
        end
    end
endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: a queue-based reference model predicts every cycle's outputs into a scoreboard,
// plus directed checks with hand-computed values for latency, filtering, fairness, overflow and reset.
module tb_writeback_arbiter;
    localparam int DEPTH  = 8;
    localparam int RW     = 5;
    localparam int MARGIN = 4;
    localparam int EW     = RW + 32;
    localparam int IW     = RW + 34;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [IW-1:0] alu_in = '0, mul_in = '0, div_in = '0;
    logic          alu_af, mul_af, div_af, rf_write;
    logic [RW-1:0] rf_rd;
    logic [31:0]   rf_data;
    logic [2:0]    overflow_err;

    writeback_arbiter #(.FIFO_DEPTH(DEPTH), .REG_WIDTH(RW), .AF_MARGIN(MARGIN)) dut (
        .clk(clk), .rst(rst),
        .alu_wb_inf(alu_in), .mul_wb_inf(mul_in), .div_wb_inf(div_in),
        .alu_almost_full(alu_af), .mul_almost_full(mul_af), .div_almost_full(div_af),
        .rf_write(rf_write), .rf_rd(rf_rd), .rf_data(rf_data), .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model state
    logic [EW-1:0] q0[$], q1[$], q2[$];
    int            m_last = 2;
    logic [RW-1:0] m_rd   = '0;
    logic [31:0]   m_data = '0;
    logic [2:0]    m_ovf  = '0;

    typedef struct {
        int          tag;
        logic        wr;
        logic [RW-1:0] rd;
        logic [31:0] data;
        logic [2:0]  af;
        logic [2:0]  ovf;
    } exp_t;
    exp_t expq[$];

    typedef struct {
        int          cyc;
        logic [RW-1:0] rd;
        logic [31:0] data;
    } wr_t;
    wr_t wlog[$];

    function automatic int qsize(input int s);
        case (s)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic logic [EW-1:0] qpop(input int s);
        case (s)
            0: return q0.pop_front();
            1: return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    function automatic void qpush(input int s, input logic [EW-1:0] x);
        case (s)
            0: q0.push_back(x);
            1: q1.push_back(x);
            default: q2.push_back(x);
        endcase
    endfunction

    function automatic logic [IW-1:0] ent(input logic iv, input logic rw, input logic [RW-1:0] rd,
                                          input logic [31:0] d);
        return {iv, rw, rd, d};
    endfunction

    // Apply current inputs to the model, queue the expected post-edge outputs, then advance one cycle.
    task automatic step();
        exp_t          e;
        logic [IW-1:0] v;
        logic [EW-1:0] x;
        int            g;
        int            s;
        g = -1;
        for (int k = 1; k <= 3; k++) begin
            s = (m_last + k) % 3;
            if (g < 0 && qsize(s) > 0) g = s;
        end
        e.wr = 1'b0;
        if (g >= 0) begin
            x      = qpop(g);
            m_rd   = x[EW-1:32];
            m_data = x[31:0];
            m_last = g;
            e.wr   = 1'b1;
        end
        for (int i = 0; i < 3; i++) begin
            v = (i == 0) ? alu_in : (i == 1) ? mul_in : div_in;
            if (v[IW-1] && v[IW-2] && v[EW-1:32] != '0) begin
                if (qsize(i) < DEPTH) qpush(i, v[EW-1:0]);
                else m_ovf[i] = 1'b1;
            end
            e.af[i] = (qsize(i) >= DEPTH - MARGIN);
        end
        e.rd   = m_rd;
        e.data = m_data;
        e.ovf  = m_ovf;
        e.tag  = cyc + 1;
        expq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [IW-1:0] a, input logic [IW-1:0] m, input logic [IW-1:0] d);
        alu_in = a;
        mul_in = m;
        div_in = d;
        step();
    endtask

    task automatic idle();
        drive('0, '0, '0);
    endtask

    task automatic reset_dut();
        alu_in = '0;
        mul_in = '0;
        div_in = '0;
        rst    = 1'b0;
        q0.delete();
        q1.delete();
        q2.delete();
        m_last = 2;
        m_rd   = '0;
        m_data = '0;
        m_ovf  = '0;
        expq.delete();
        #1;
        chk("rst_rf_write", 64'(rf_write), 64'(0));
        chk("rst_rf_rd", 64'(rf_rd), 64'(0));
        chk("rst_rf_data", 64'(rf_data), 64'(0));
        chk("rst_almost_full", 64'({div_af, mul_af, alu_af}), 64'(0));
        chk("rst_overflow_err", 64'(overflow_err), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        exp_t e;
        wr_t  w;
        if (rst) begin
            if (rf_write === 1'b1) begin
                w.cyc  = cyc;
                w.rd   = rf_rd;
                w.data = rf_data;
                wlog.push_back(w);
            end
            while (expq.size() > 0 && expq[0].tag <= cyc) begin
                e = expq.pop_front();
                chk("sb_rf_write", 64'(rf_write), 64'(e.wr));
                chk("sb_rf_rd", 64'(rf_rd), 64'(e.rd));
                chk("sb_rf_data", 64'(rf_data), 64'(e.data));
                chk("sb_almost_full", 64'({div_af, mul_af, alu_af}), 64'(e.af));
                chk("sb_overflow_err", 64'(overflow_err), 64'(e.ovf));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int          c0;
        int          na, nm, nd;
        logic        seen;
        logic [31:0] base [3];
        base[0] = 32'hA000_0000;
        base[1] = 32'hB000_0000;
        base[2] = 32'hC000_0000;

        // Power-on reset
        reset_dut();

        // Single ALU write: visible two cycles after the input
        wlog.delete();
        c0 = cyc;
        drive(ent(1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF), '0, '0);
        repeat (4) idle();
        chk("single_count", 64'(wlog.size()), 64'(1));
        if (wlog.size() >= 1) begin
            chk("single_rd", 64'(wlog[0].rd), 64'(5));
            chk("single_data", 64'(wlog[0].data), 64'(32'hDEAD_BEEF));
            chk("single_latency", 64'(wlog[0].cyc - c0), 64'(2));
        end

        // Filtered inputs: rd=0, no register_write, no instruction_valid
        wlog.delete();
        drive(ent(1'b1, 1'b1, 5'd0, 32'h111), ent(1'b1, 1'b0, 5'd3, 32'h222), ent(1'b0, 1'b1, 5'd4, 32'h333));
        repeat (3) idle();
        chk("filter_count", 64'(wlog.size()), 64'(0));

        // Round-robin fairness: 4 entries from each unit on the same cycles
        reset_dut();
        wlog.delete();
        c0 = cyc;
        for (int i = 0; i < 4; i++)
            drive(ent(1'b1, 1'b1, 5'd1, base[0] + 32'(i)), ent(1'b1, 1'b1, 5'd2, base[1] + 32'(i)),
                  ent(1'b1, 1'b1, 5'd3, base[2] + 32'(i)));
        repeat (12) idle();
        chk("rr_count", 64'(wlog.size()), 64'(12));
        for (int i = 0; i < 12; i++) begin
            if (i < wlog.size()) begin
                chk("rr_data", 64'(wlog[i].data), 64'(base[i % 3] + 32'(i / 3)));
                chk("rr_rd", 64'(wlog[i].rd), 64'(i % 3 + 1));
                chk("rr_cycle", 64'(wlog[i].cyc - c0), 64'(i + 2));
            end
        end

        // Almost-full and overflow under three-way contention
        reset_dut();
        wlog.delete();
        for (int i = 0; i < 13; i++) begin
            drive(ent(1'b1, 1'b1, 5'd1, 32'hA500_0000 + 32'(i)), ent(1'b1, 1'b1, 5'd2, 32'hB500_0000 + 32'(i)),
                  ent(1'b1, 1'b1, 5'd3, 32'hC500_0000 + 32'(i)));
            if (i == 3)  chk("mul_af_below", 64'(mul_af), 64'(0));
            if (i == 4)  chk("mul_af_rise", 64'(mul_af), 64'(1));
            if (i == 11) chk("ovf_div_only", 64'(overflow_err), 64'(3'b100));
            if (i == 12) chk("ovf_all", 64'(overflow_err), 64'(3'b111));
        end
        repeat (45) idle();
        chk("ovf_write_count", 64'(wlog.size()), 64'(36));
        na = 0;
        nm = 0;
        nd = 0;
        seen = 1'b0;
        foreach (wlog[i]) begin
            if (wlog[i].data[31:24] == 8'hA5) na++;
            if (wlog[i].data[31:24] == 8'hB5) nm++;
            if (wlog[i].data[31:24] == 8'hC5) nd++;
            if (wlog[i].data == 32'hB500_000B) seen = 1'b1;
        end
        chk("ovf_alu_writes", 64'(na), 64'(12));
        chk("ovf_mul_writes", 64'(nm), 64'(12));
        chk("ovf_div_writes", 64'(nd), 64'(12));
        chk("full_push_pop_kept", 64'(seen), 64'(1));
        chk("ovf_sticky", 64'(overflow_err), 64'(3'b111));

        // Reset in the middle of traffic
        for (int i = 0; i < 4; i++)
            drive(ent(1'b1, 1'b1, 5'd4, 32'hD000_0000 + 32'(i)), ent(1'b1, 1'b1, 5'd5, 32'hD100_0000 + 32'(i)),
                  ent(1'b1, 1'b1, 5'd6, 32'hD200_0000 + 32'(i)));
        chk("mid_busy", 64'(rf_write), 64'(1));
        reset_dut();
        wlog.delete();
        repeat (3) idle();
        chk("no_stale_writes", 64'(wlog.size()), 64'(0));
        c0 = cyc;
        drive(ent(1'b1, 1'b1, 5'd7, 32'hE1), ent(1'b1, 1'b1, 5'd8, 32'hE2), ent(1'b1, 1'b1, 5'd9, 32'hE3));
        repeat (5) idle();
        chk("post_rst_count", 64'(wlog.size()), 64'(3));
        for (int i = 0; i < 3; i++) begin
            if (i < wlog.size()) begin
                chk("post_rst_order", 64'(wlog[i].rd), 64'(7 + i));
                chk("post_rst_cycle", 64'(wlog[i].cyc - c0), 64'(2 + i));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
